data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Parametrised load/store data memory with a valid/ready request channel and a valid/ready response channel.
- Holds internal byte-lane word storage of configurable depth and decodes the RV32 load/store memop (lb/lh/lw/lbu/lhu, sb/sh/sw).
- Read latency is programmable; misaligned, illegal and out-of-range accesses are reported.
- Sits between the CPU memory stage and the data RAM; supports multi-cycle (stalling) cores.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words stored.
- ADDR_W, 17, width of byte address port; must be >= DEPTH_LOG2+2.
- READ_LAT, 1, cycles from request accept to read data available; legal 1..4.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_memop  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data; low byte/half/word used per memop.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access was misaligned, illegal or out of range.

Behaviour:
- Reset (asynchronous): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline cleared. Memory contents are not reset.
- One outstanding transaction. Accept happens when req_valid && req_ready at a rising edge (edge T). All request fields are captured at edge T.
- FSM states:
  - IDLE: req_ready=1. Accept moves to WRITE, READ or ERR.
  - READ: counts READ_LAT edges, then moves to RESP.
  - WRITE/ERR: one cycle, then RESP.
  - RESP: rsp_valid=1, outputs held stable until rsp_valid && rsp_ready at an edge, then IDLE.
- req_ready=0 in every state except IDLE. A request arriving during RESP is not accepted in the same cycle as the response handshake; it is accepted one cycle later.
- Latency:
  - Load: rsp_valid rises after edge T+READ_LAT.
  - Store or error: rsp_valid rises after edge T+1.
  - With rsp_ready tied high, a load occupies READ_LAT+1 cycles and a store occupies 2 cycles.
- Error conditions, evaluated at accept:
  - h/hu with addr[0]=1.
  - w with addr[1:0]!=00.
  - memop 011, 110 or 111.
  - store with memop 100 or 101.
  - word index addr[ADDR_W-1:2] >= 2^DEPTH_LOG2.
  - Effect: no memory write, rsp_err=1, rsp_rdata=0.
- Store byte-lane mask:
  - sb: lane addr[1:0].
  - sh: lanes {1,0} if addr[1]=0, else {3,2}.
  - sw: all lanes.
  - The memory write commits at edge T.
- Store data: sb replicates wdata[7:0] four times; sh replicates wdata[15:0] twice; sw passes wdata unchanged.
- Load extraction: half selected by addr[1]; byte selected by addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw returns the full word.
- Read-after-write: a load accepted the cycle after a store's response sees the stored data; no forwarding is needed because there is one outstanding transaction.
- Reset mid-operation: a pending read or response is discarded. A store already committed at edge T remains in memory.

Optional Feature:
- Macro: DATA_MEM_STATS_EN.
- Defined: adds outputs stat_loads[15:0], stat_stores[15:0] and stat_errs[15:0]. Each increments once per accepted request of its class (errors count only as errs), saturates at 16'hFFFF, and is cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- READ_LAT=1, rsp_ready=1: sw addr 0x10 wdata 0x8899AABB, then lw 0x10 -> store rsp_valid 1 cycle after accept with err=0, rdata=0; load rdata=0x8899AABB exactly 1 cycle after accept.
- Byte/half lanes: sb 0x21 wdata 0x000000F0 over word 0 at 0x20 -> lw 0x20 = 0x0000F000; lb 0x21 = 0xFFFFFFF0; lbu 0x21 = 0x000000F0; sh 0x22 0x1234 -> lhu 0x22 = 0x00001234.
- Errors: lw 0x13, sh 0x05, memop 011, addr word index 2^DEPTH_LOG2 -> each gives rsp_err=1, rdata=0, and the memory word is unchanged (verified by a follow-up lw).
- Backpressure, READ_LAT=3: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid/rdata stable, req_ready=0 throughout; the next request is accepted only in the cycle after the handshake.
- Reset asserted asynchronously mid-READ -> rsp_valid=0 and req_ready=1 immediately; no response emitted; memory retains earlier stores.
- DATA_MEM_STATS_EN: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errs=1; force 65540 loads -> stat_loads=0xFFFF.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// RV32 load/store data memory with valid/ready request and response channels.
// Define DATA_MEM_STATS_EN to add saturating load/store/error counters.
module data_mem_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int ADDR_W     = 17,
    parameter int READ_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, RESP} state_t;

    state_t                state;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_word;
    logic [1:0]            cnt;
    logic [2:0]            op_q;
    logic [1:0]            lane_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor;
    logic                  illegal;
    logic                  misal;
    logic                  err;
    logic                  accept;
    logic [3:0]            mask;
    logic [31:0]           wrep;
    logic [31:0]           shifted;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           load_data;

    assign idx    = req_addr[DEPTH_LOG2+1:2];
    assign accept = req_valid && req_ready;

    generate
        if (ADDR_W > DEPTH_LOG2 + 2) begin : g_range
            assign oor = |req_addr[ADDR_W-1:DEPTH_LOG2+2];
        end else begin : g_full
            assign oor = 1'b0;
        end
    endgenerate

    // Stores only accept b/h/w; bu/hu encodings are load-only.
    always_comb begin
        illegal = (req_memop == 3'b011) || (req_memop[2:1] == 2'b11)
                || (req_we && req_memop[2]);
        misal   = (req_memop[1:0] == 2'b01 && req_addr[0])
                || (req_memop == 3'b010 && req_addr[1:0] != 2'b00);
        err     = illegal || misal || oor;
    end

    always_comb begin
        mask = 4'b0000;
        wrep = req_wdata;
        case (req_memop[1:0])
            2'b00: begin
                mask = 4'b0001 << req_addr[1:0];
                wrep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                mask = req_addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{req_wdata[15:0]}};
            end
            2'b10: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

    // Store commits at the accept edge; loads take a synchronous read there too.
    always_ff @(posedge clock) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
        if (accept) rd_word <= mem[idx];
    end

    always_comb begin
        shifted   = rd_word >> {lane_q, 3'b000};
        byte_v    = shifted[7:0];
        half_v    = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'h0;
        case (op_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, byte_v};
            3'b101:  load_data = {16'h0, half_v};
            default: load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt       <= 2'd0;
            op_q      <= 3'd0;
            lane_q    <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_memop;
                        lane_q    <= req_addr[1:0];
                        cnt       <= CNT_INIT;
                        if (err)         state <= ERR;
                        else if (req_we) state <= WRITE;
                        else             state <= READ;
                    end
                end
                READ: begin
                    if (cnt == 2'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_data;
                        rsp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
                ERR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_MEM_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_loads  <= 16'h0;
            stat_stores <= 16'h0;
            stat_errs   <= 16'h0;
        end else if (accept) begin
            if (err) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (req_we) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule
